// File: rtl/song_reader.sv
// Purpose : walks note words in the song RAM from base_addr, presenting each note and holding it for its duration in beats.
// Latency : play rising in IDLE -> ram_addr=base next cycle -> note/new_note 3 cycles after play; 3-cycle gap between notes.
// Backpressure: play=0 pauses the beat count in PLAY; an in-flight fetch always completes regardless of play.
//
// Ports:
//   clk, reset   single clock, synchronous active-high reset
//   play         level run/pause; beat one-cycle tempo tick
//   base_addr    first word address, sampled when leaving IDLE
//   ram_addr     address to the RAM read port (registered)
//   ram_dout     RAM read data, valid one cycle after ram_addr
//   note         current note (registered); new_note pulses when it changes
//   note_active  high while a note is being held
//   song_done    one-cycle pulse at end of song
module song_reader #(
  parameter int ADDR_W = 8,
  parameter int NOTE_W = 6,
  parameter int DUR_W  = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      play,
  input  logic                      beat,
  input  logic [ADDR_W-1:0]         base_addr,
  output logic [ADDR_W-1:0]         ram_addr,
  input  logic [NOTE_W+DUR_W-1:0]   ram_dout,
  output logic [NOTE_W-1:0]         note,
  output logic                      new_note,
  output logic                      note_active,
  output logic                      song_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    PLAY,
    DONE
  } state_t;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   addr, addr_n;
  logic [DUR_W-1:0]    left, left_n;
  logic                first, first_n;
  logic [NOTE_W-1:0]   note_n;
  logic                new_note_n;
  logic                song_done_n;
  logic                count_beat;

  logic [DUR_W-1:0]    word_dur;
  logic [NOTE_W-1:0]   word_note;

  assign word_dur    = ram_dout[DUR_W-1:0];
  assign word_note   = ram_dout[NOTE_W+DUR_W-1:DUR_W];
  assign ram_addr    = addr;
  assign note_active = (state == PLAY);

  always_comb begin
    state_n     = state;
    addr_n      = addr;
    left_n      = left;
    first_n     = first;
    note_n      = note;
    new_note_n  = 1'b0;
    song_done_n = 1'b0;
    count_beat  = 1'b0;

    case (state)
      IDLE: begin
        if (play) begin
          addr_n  = base_addr;
          state_n = FETCH;
        end
      end

      // RAM captures addr at the end of this cycle; data shows up in DECODE.
      FETCH: state_n = DECODE;

      DECODE: begin
        if (word_dur == '0) begin
          state_n     = DONE;
          song_done_n = 1'b1;
        end else begin
          note_n     = word_note;
          left_n     = word_dur;
          first_n    = 1'b1;
          new_note_n = 1'b1;
          state_n    = PLAY;
        end
      end

      PLAY: begin
        // The note starts on a beat: the first PLAY cycle counts as one,
        // and that pending credit survives a pause until it is used.
        count_beat = play & (beat | first);
        if (count_beat) begin
          first_n = 1'b0;
          if (left == DUR_W'(1)) begin
            if (addr == LAST_ADDR) begin
              // End of address space: finish rather than wrap to 0.
              state_n     = DONE;
              song_done_n = 1'b1;
            end else begin
              addr_n  = addr + ADDR_W'(1);
              state_n = FETCH;
            end
          end else begin
            left_n = left - DUR_W'(1);
          end
        end
      end

      // Stay here until play drops so a held play level cannot replay.
      DONE: begin
        if (!play) begin
          state_n = IDLE;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      addr      <= '0;
      left      <= '0;
      first     <= 1'b0;
      note      <= '0;
      new_note  <= 1'b0;
      song_done <= 1'b0;
    end else begin
      state     <= state_n;
      addr      <= addr_n;
      left      <= left_n;
      first     <= first_n;
      note      <= note_n;
      new_note  <= new_note_n;
      song_done <= song_done_n;
    end
  end

endmodule

// File: tb/tb_song_reader.sv
module tb_song_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        play;
  logic        beat;
  logic [7:0]  base_addr;
  logic [7:0]  ram_addr;
  logic [11:0] ram_dout;
  logic [5:0]  note;
  logic        new_note;
  logic        note_active;
  logic        song_done;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;
  bit beat_on = 1'b0;

  logic [11:0] mem [0:255];

  always #5 clk = ~clk;

  song_reader #(.ADDR_W(8), .NOTE_W(6), .DUR_W(6)) dut (
    .clk         (clk),
    .reset       (reset),
    .play        (play),
    .beat        (beat),
    .base_addr   (base_addr),
    .ram_addr    (ram_addr),
    .ram_dout    (ram_dout),
    .note        (note),
    .new_note    (new_note),
    .note_active (note_active),
    .song_done   (song_done)
  );

  // Synchronous-read RAM port B.
  always @(posedge clk) ram_dout <= mem[ram_addr];

  // ---------------- reference model ----------------
  // Song-level view: idle, loading a word (fixed 3-edge latency from the
  // triggering edge), holding a note for a number of beats, or finished.
  localparam int M_IDLE = 0, M_LOAD = 1, M_HOLD = 2, M_FIN = 3;
  int       m_mode  = M_IDLE;
  int       m_wait  = 0;
  int       m_addr  = 0;
  int       m_beats = 0;
  bit       m_credit = 0;
  int       m_note  = 0;
  bit       m_new   = 0;
  bit       m_done  = 0;
  logic [11:0] w;

  always @(posedge clk) begin
    if (reset) begin
      m_mode = M_IDLE; m_addr = 0; m_note = 0; m_new = 0; m_done = 0;
      m_beats = 0; m_credit = 0; m_wait = 0;
    end else begin
      m_new  = 0;
      m_done = 0;
      if (m_mode == M_IDLE) begin
        if (play) begin
          m_addr = base_addr; m_mode = M_LOAD; m_wait = 2;
        end
      end else if (m_mode == M_LOAD) begin
        m_wait = m_wait - 1;
        if (m_wait == 0) begin
          w = mem[m_addr];
          if (w[5:0] == 0) begin
            m_mode = M_FIN; m_done = 1;
          end else begin
            m_note = w[11:6]; m_beats = w[5:0]; m_credit = 1;
            m_new = 1; m_mode = M_HOLD;
          end
        end
      end else if (m_mode == M_HOLD) begin
        if (play && (beat || m_credit)) begin
          m_credit = 0;
          m_beats  = m_beats - 1;
          if (m_beats == 0) begin
            if (m_addr == 255) begin
              m_mode = M_FIN; m_done = 1;
            end else begin
              m_addr = m_addr + 1; m_mode = M_LOAD; m_wait = 2;
            end
          end
        end
      end else begin
        if (!play) m_mode = M_IDLE;
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("ram_addr",    32'(ram_addr),    32'(m_addr[7:0]));
      check("note",        32'(note),        32'(m_note));
      check("new_note",    32'(new_note),    32'(m_new));
      check("note_active", 32'(note_active), 32'(m_mode == M_HOLD));
      check("song_done",   32'(song_done),   32'(m_done));
    end
  end

  // Beat generator: one pulse every 4 cycles while enabled.
  initial begin
    int ph;
    ph = 0;
    beat = 1'b0;
    forever begin
      @(negedge clk);
      if (beat_on) begin
        ph = (ph + 1) % 4;
        beat = (ph == 0);
      end else begin
        beat = 1'b0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Wait for new_note (sel=0) or song_done (sel=1); returns cycles waited.
  task automatic wait_pulse(input int sel, input int max, input string nm, output int n);
    bit seen;
    seen = 0;
    n = 0;
    while (!seen && n < max) begin
      @(negedge clk);
      n++;
      seen = (sel == 0) ? new_note : song_done;
    end
    if (!seen) begin
      errors++;
      checks++;
      $display("FAIL %s: timeout after %0d cycles, required pulse", nm, max);
    end
  endtask

  initial begin
    int n;
    int pulses;
    int news;
    bit saw0;

    for (int i = 0; i < 256; i++) mem[i] = 12'h000;
    mem[8'h10] = {6'd5, 6'd2};
    mem[8'h11] = {6'd9, 6'd1};
    mem[8'h12] = {6'd0, 6'd0};
    mem[8'h20] = {6'd7, 6'd3};
    mem[8'h21] = {6'd0, 6'd0};
    mem[8'hFF] = {6'd3, 6'd1};
    mem[8'h30] = {6'd4, 6'd0};

    reset = 1'b1; play = 1'b0; base_addr = 8'h00;
    @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(2);

    // 1: basic three-word song
    base_addr = 8'h10; play = 1'b1; beat_on = 1'b1;
    wait_pulse(0, 20, "t1 first note", n);
    check("t1 first note latency", 32'(n), 32'd3);
    check("t1 first note value", 32'(note), 32'd5);
    wait_pulse(0, 50, "t1 second note", n);
    check("t1 second note value", 32'(note), 32'd9);
    wait_pulse(1, 50, "t1 done", n);
    tick(10);
    check("t1 final ram_addr", 32'(ram_addr), 32'h12);
    play = 1'b0;
    tick(3);

    // 2: pause mid-note
    base_addr = 8'h20; play = 1'b1;
    wait_pulse(0, 20, "t2 note", n);
    check("t2 note value", 32'(note), 32'd7);
    tick(2);
    play = 1'b0;
    tick(20);
    check("t2 paused note_active", 32'(note_active), 32'd1);
    check("t2 paused note", 32'(note), 32'd7);
    play = 1'b1;
    wait_pulse(1, 60, "t2 done", n);
    play = 1'b0;
    tick(3);

    // 3: last address, no wrap
    base_addr = 8'hFF; play = 1'b1;
    saw0 = 0;
    pulses = 0;
    n = 0;
    while (pulses == 0 && n < 40) begin
      @(negedge clk);
      n++;
      if (ram_addr == 8'h00) saw0 = 1;
      if (new_note) check("t3 note value", 32'(note), 32'd3);
      if (song_done) pulses++;
    end
    check("t3 done seen", 32'(pulses), 32'd1);
    tick(5);
    if (ram_addr == 8'h00) saw0 = 1;
    check("t3 ram_addr never 0", 32'(saw0), 32'd0);
    play = 1'b0;
    tick(3);

    // 4: empty song
    base_addr = 8'h30; play = 1'b1;
    wait_pulse(1, 20, "t4 done", n);
    check("t4 done latency", 32'(n), 32'd3);
    play = 1'b0;
    tick(3);

    // 5: reset while playing, then restart from base
    base_addr = 8'h10; play = 1'b1;
    wait_pulse(0, 20, "t5 note", n);
    tick(1);
    reset = 1'b1;
    tick(1);
    check("t5 reset ram_addr", 32'(ram_addr), 32'd0);
    check("t5 reset note", 32'(note), 32'd0);
    check("t5 reset note_active", 32'(note_active), 32'd0);
    check("t5 reset new_note", 32'(new_note), 32'd0);
    check("t5 reset song_done", 32'(song_done), 32'd0);
    reset = 1'b0;
    wait_pulse(0, 20, "t5 restart", n);
    check("t5 restart latency", 32'(n), 32'd3);
    check("t5 restart note", 32'(note), 32'd5);
    wait_pulse(1, 60, "t5 done", n);

    // 6: hold play after done, then replay
    tick(1);
    pulses = 0;
    news = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (song_done) pulses++;
      if (new_note) news++;
    end
    check("t6 no second done", 32'(pulses), 32'd0);
    check("t6 no refetch note", 32'(news), 32'd0);
    check("t6 held ram_addr", 32'(ram_addr), 32'h12);
    play = 1'b0;
    tick(1);
    play = 1'b1;
    wait_pulse(0, 20, "t6 replay", n);
    check("t6 replay latency", 32'(n), 32'd3);
    check("t6 replay note", 32'(note), 32'd5);
    wait_pulse(1, 60, "t6 done", n);
    play = 1'b0;
    tick(3);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

endmodule
